// File: rtl/adder_acc_pipe_if.sv
// Operand/result handshake bundle for adder_acc_pipe.
// master = operand source and result consumer; slave = the adder itself.
interface adder_acc_pipe_if #(
    parameter int WIDTH   = 8,
    parameter int ACC_LEN = 4
);
    localparam int OUT_W = WIDTH + 1 + $clog2(ACC_LEN);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [1:0]       mode;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out;
    logic             neg;
    logic             partial;

    modport master (
        output in_valid, in1, in2, mode, flush, out_ready,
        input  in_ready, out_valid, out, neg, partial
    );

    modport slave (
        input  in_valid, in1, in2, mode, flush, out_ready,
        output in_ready, out_valid, out, neg, partial
    );
endinterface

// File: rtl/adder_acc_pipe.sv
// Registered add / subtract / block-accumulate unit with valid/ready on both sides.
// A single output register holds each result until the consumer takes it.
module adder_acc_pipe #(
    parameter int WIDTH   = 8,
    parameter int ACC_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    adder_acc_pipe_if.slave  bus
);
    localparam int OUT_W = WIDTH + 1 + $clog2(ACC_LEN);
    localparam int CNT_W = $clog2(ACC_LEN + 1);

    typedef enum logic {IDLE, ACC} state_t;
    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_RSV = 2'b11
    } mode_t;

    state_t           state, state_n;
    logic [OUT_W-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic [OUT_W-1:0] out_q;
    logic             out_valid_q;
    logic             neg_q;
    logic             partial_q;

    logic             in_ready;
    logic             accept;
    logic [OUT_W-1:0] beat_sum;
    logic [OUT_W-1:0] beat_diff;
    logic [OUT_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_inc;
    logic             block_done;

    logic             load;
    logic [OUT_W-1:0] load_val;
    logic             load_neg;
    logic             load_partial;

    // Loads only happen when in_ready is high, so a stalled result is never overwritten.
    assign in_ready   = !out_valid_q || bus.out_ready;
    assign accept     = bus.in_valid && in_ready;
    assign beat_sum   = OUT_W'(bus.in1) + OUT_W'(bus.in2);
    assign beat_diff  = OUT_W'(bus.in1) - OUT_W'(bus.in2);
    assign acc_sum    = acc + beat_sum;
    assign cnt_inc    = cnt + CNT_W'(1);
    assign block_done = (cnt_inc == CNT_W'(ACC_LEN));

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.neg       = neg_q;
    assign bus.partial   = partial_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        acc_n        = acc;
        cnt_n        = cnt;
        load         = 1'b0;
        load_val     = '0;
        load_neg     = 1'b0;
        load_partial = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.mode == MODE_ACC) begin
                        state_n = ACC;
                        acc_n   = beat_sum;
                        cnt_n   = CNT_W'(1);
                    end else begin
                        load = 1'b1;
                        if (bus.mode == MODE_SUB) begin
                            load_val = beat_diff;
                            load_neg = (bus.in1 < bus.in2);
                        end else begin
                            load_val = beat_sum;
                        end
                    end
                end
            end
            ACC: begin
                // A beat arriving with flush is folded in before the block closes.
                if (accept) begin
                    if (block_done || bus.flush) begin
                        load         = 1'b1;
                        load_val     = acc_sum;
                        load_partial = !block_done;
                        state_n      = IDLE;
                        acc_n        = '0;
                        cnt_n        = '0;
                    end else begin
                        acc_n = acc_sum;
                        cnt_n = cnt_inc;
                    end
                end else if (bus.flush && in_ready) begin
                    load         = 1'b1;
                    load_val     = acc;
                    load_partial = 1'b1;
                    state_n      = IDLE;
                    acc_n        = '0;
                    cnt_n        = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            neg_q       <= 1'b0;
            partial_q   <= 1'b0;
        end else if (load) begin
            out_q       <= load_val;
            out_valid_q <= 1'b1;
            neg_q       <= load_neg;
            partial_q   <= load_partial;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule
